// File: rtl/adc_peak_detect.sv
// Peak-magnitude detector for the de-randomized LT2208 sample stream.
// Reports one windowed peak through a valid/ack handshake and flags a stretched overload.
module adc_peak_detect #(
   parameter int          WINDOW   = 4096,
   parameter logic [14:0] THRESH   = 15'h7F00,
   parameter int          OVL_HOLD = 122880
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] ADC_in,
   input  logic        ADC_OVR,
   input  logic        peak_ack,
   output logic [14:0] peak_out,
   output logic        peak_valid,
   output logic        peak_lost,
   output logic        overload
);

   localparam int             WCW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WCW-1:0] WIN_LAST  = WCW'(WINDOW - 1);
   localparam logic [23:0]    HOLD_LOAD = 24'(OVL_HOLD);

   logic [14:0]    mag_q;
   logic           trig_q;
   logic           magValid_q;
   logic [14:0]    runMax_q, runMax_d;
   logic [WCW-1:0] winCnt_q, winCnt_d;
   logic [14:0]    peak_q, peak_d;
   logic           valid_q, valid_d;
   logic           lost_q, lost_d;
   logic [23:0]    hold_q, hold_d;
   logic           ovl_q, ovl_d;

   logic [14:0]    magIn;
   logic [14:0]    maxNext;

   // One's-complement magnitude keeps -32768 inside 15 bits without a wider intermediate.
   assign magIn   = ADC_in[15] ? ~ADC_in[14:0] : ADC_in[14:0];
   assign maxNext = (mag_q > runMax_q) ? mag_q : runMax_q;

   always_comb begin
      winCnt_d = winCnt_q;
      runMax_d = runMax_q;
      peak_d   = peak_q;
      valid_d  = valid_q;
      lost_d   = lost_q;
      if (peak_ack) begin
         valid_d = 1'b0;
      end
      // A window completion overrides a simultaneous ack.
      if (magValid_q) begin
         if (winCnt_q == WIN_LAST) begin
            peak_d   = maxNext;
            runMax_d = '0;
            winCnt_d = '0;
            valid_d  = 1'b1;
            if (valid_q && !peak_ack) begin
               lost_d = 1'b1;
            end
         end else begin
            winCnt_d = winCnt_q + 1'b1;
            runMax_d = maxNext;
         end
      end

      if (trig_q) begin
         hold_d = HOLD_LOAD;
         ovl_d  = 1'b1;
      end else if (hold_q > 24'd1) begin
         hold_d = hold_q - 24'd1;
         ovl_d  = 1'b1;
      end else begin
         hold_d = '0;
         ovl_d  = 1'b0;
      end
   end

   // magValid_q holds stage 2 off until the first post-reset sample reaches it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mag_q      <= '0;
         trig_q     <= 1'b0;
         magValid_q <= 1'b0;
         runMax_q   <= '0;
         winCnt_q   <= '0;
         peak_q     <= '0;
         valid_q    <= 1'b0;
         lost_q     <= 1'b0;
         hold_q     <= '0;
         ovl_q      <= 1'b0;
      end else begin
         mag_q      <= magIn;
         trig_q     <= ADC_OVR | (magIn >= THRESH);
         magValid_q <= 1'b1;
         runMax_q   <= runMax_d;
         winCnt_q   <= winCnt_d;
         peak_q     <= peak_d;
         valid_q    <= valid_d;
         lost_q     <= lost_d;
         hold_q     <= hold_d;
         ovl_q      <= ovl_d;
      end
   end

   assign peak_out   = peak_q;
   assign peak_valid = valid_q;
   assign peak_lost  = lost_q;
   assign overload   = ovl_q;

endmodule

// File: tb/tb_adc_peak_detect.sv
// Randomized and directed bench for adc_peak_detect, checked every cycle against
// an event-timed behavioural model plus literal expectations for the key scenarios.
module tb_adc_peak_detect;

   localparam int WINDOW   = 8;
   localparam int THRESH   = 1000;
   localparam int OVL_HOLD = 5;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] adcIn;
   logic        adcOvr;
   logic        peakAck;
   logic [14:0] peakOut;
   logic        peakValid;
   logic        peakLost;
   logic        overload;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   adc_peak_detect #(
      .WINDOW  (WINDOW),
      .THRESH  (15'(THRESH)),
      .OVL_HOLD(OVL_HOLD)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .ADC_in    (adcIn),
      .ADC_OVR   (adcOvr),
      .peak_ack  (peakAck),
      .peak_out  (peakOut),
      .peak_valid(peakValid),
      .peak_lost (peakLost),
      .overload  (overload)
   );

   // Model state: edges are numbered, samples are gathered per window, and overload
   // is derived from the edge number of the most recent trigger.
   int          edgeNum   = 0;
   bit          live      = 1'b0;
   int          winQ[$];
   bit          pend      = 1'b0;
   int          pendVal   = 0;
   bit          haveTrig  = 1'b0;
   int          lastTrig  = 0;
   logic [14:0] expPeak   = '0;
   bit          expValid  = 1'b0;
   bit          expLost   = 1'b0;
   bit          expOvl    = 1'b0;

   function automatic int oneMag(input logic [15:0] s);
      int v;
      v = int'($signed(s));
      return (v < 0) ? (-v - 1) : v;
   endfunction

   always @(posedge clock) begin
      int m;
      int mx;
      edgeNum++;
      if (!reset_n) begin
         live     = 1'b1;
         winQ.delete();
         pend     = 1'b0;
         haveTrig = 1'b0;
         expPeak  = '0;
         expValid = 1'b0;
         expLost  = 1'b0;
         expOvl   = 1'b0;
      end else begin
         expOvl = haveTrig && ((edgeNum - lastTrig) <= OVL_HOLD);
         if (pend) begin
            expPeak = 15'(pendVal);
            if (expValid && !peakAck) expLost = 1'b1;
            expValid = 1'b1;
            pend     = 1'b0;
         end else if (peakAck) begin
            expValid = 1'b0;
         end
         m = oneMag(adcIn);
         winQ.push_back(m);
         if (winQ.size() == WINDOW) begin
            mx = 0;
            foreach (winQ[i]) if (winQ[i] > mx) mx = winQ[i];
            pendVal = mx;
            pend    = 1'b1;
            winQ.delete();
         end
         if (adcOvr || (m >= THRESH)) begin
            haveTrig = 1'b1;
            lastTrig = edgeNum;
         end
      end
   end

   task automatic compareOne(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeNum, actual, expected);
      end
   endtask

   task automatic checkOutput();
      compareOne("model peak_out",   32'(peakOut),   32'(expPeak));
      compareOne("model peak_valid", 32'(peakValid), 32'(expValid));
      compareOne("model peak_lost",  32'(peakLost),  32'(expLost));
      compareOne("model overload",   32'(overload),  32'(expOvl));
   endtask

   always @(negedge clock) begin
      if (live) checkOutput();
   end

   task automatic applyStimulus(input logic [15:0] s, input logic ovr, input logic ack, input logic rstN);
      @(negedge clock);
      adcIn   = s;
      adcOvr  = ovr;
      peakAck = ack;
      reset_n = rstN;
   endtask

   logic [15:0] winTwo [8];
   logic [15:0] winB   [8];

   initial begin
      reset_n = 1'b0;
      adcIn   = '0;
      adcOvr  = 1'b1;
      peakAck = 1'b0;
      winTwo  = '{16'd100, 16'hFF38, 16'd50, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd7};
      winB    = '{16'd5, 16'd5, 16'd5, 16'd1234, 16'd5, 16'd5, 16'd5, 16'd5};

      // Reset with noisy inputs and OVR held high.
      repeat (4) applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0);
      compareOne("reset peak_out",   32'(peakOut),   0);
      compareOne("reset peak_valid", 32'(peakValid), 0);
      compareOne("reset peak_lost",  32'(peakLost),  0);
      compareOne("reset overload",   32'(overload),  0);

      // First window of zeros, then peak extremes with no acks at all.
      repeat (8) applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(winTwo[0], 1'b0, 1'b0, 1'b1);
      compareOne("latency valid low", 32'(peakValid), 0);
      applyStimulus(winTwo[1], 1'b0, 1'b0, 1'b1);
      compareOne("first window valid", 32'(peakValid), 1);
      compareOne("first window peak",  32'(peakOut),   0);
      for (int i = 2; i < 8; i++) applyStimulus(winTwo[i], 1'b0, 1'b0, 1'b1);
      applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1);
      compareOne("peak of -32768", 32'(peakOut), 32767);
      repeat (6) applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      compareOne("peak of all -1", 32'(peakOut),  0);
      compareOne("lost after 3",   32'(peakLost), 1);
      repeat (5) applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd300, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      compareOne("last sample peak", 32'(peakOut), 300);

      // Acked windows, then an ack landing on the completion cycle.
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 8; i++) begin
            applyStimulus(16'($urandom), 1'b0, (w > 0 && i == 1), 1'b1);
            if (w > 0 && i == 1) compareOne("valid before ack", 32'(peakValid), 1);
            if (w > 0 && i == 2) compareOne("valid after ack",  32'(peakValid), 0);
         end
      end
      for (int i = 0; i < 8; i++) applyStimulus(winB[i], 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b1, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      compareOne("ack on completion valid", 32'(peakValid), 1);
      compareOne("ack on completion peak",  32'(peakOut),   1234);
      compareOne("ack on completion lost",  32'(peakLost),  0);

      // Threshold overload at, just below and just beyond THRESH.
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
      repeat (8) applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd1000, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
         compareOne("thresh hold shape", 32'(overload), 32'(k >= 2 && k <= 6));
      end
      applyStimulus(16'd999, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'hFC19, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
         compareOne("below thresh quiet", 32'(overload), 0);
      end
      applyStimulus(16'hFC17, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      compareOne("neg 1001 triggers", 32'(overload), 1);
      repeat (8) applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);

      // OVR pulse retriggered three clocks later.
      applyStimulus(16'd0, 1'b1, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      compareOne("ovr not yet", 32'(overload), 0);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      compareOne("ovr rises", 32'(overload), 1);
      applyStimulus(16'd0, 1'b1, 1'b0, 1'b1);
      compareOne("ovr between pulses", 32'(overload), 1);
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
         compareOne("ovr retrigger shape", 32'(overload), 32'(k <= 6));
      end

      // Reset mid-window and mid-hold, then a full fresh window.
      applyStimulus(16'd0, 1'b1, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'd50, 1'b0, 1'b0, 1'b1);
      compareOne("mid reset overload", 32'(overload),  0);
      compareOne("mid reset valid",    32'(peakValid), 0);
      repeat (7) applyStimulus(16'd20, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      compareOne("post reset not early", 32'(peakValid), 0);
      applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);
      compareOne("post reset valid", 32'(peakValid), 1);
      compareOne("post reset peak",  32'(peakOut),   50);

      // Random traffic against the model.
      for (int c = 0; c < 800; c++) begin
         logic [15:0] s;
         s = 16'($urandom);
         if ($urandom_range(0, 2) == 0) s = 16'($urandom_range(0, 2000)) - 16'd1000;
         applyStimulus(s, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 149) != 0));
      end
      repeat (3) applyStimulus(16'd0, 1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
